// File: rtl/rip_branch_pht.sv
// rip_branch_pht: pattern history table of 2-bit saturating counters for the
// fetch-stage branch predictor.
//   Optional gshare indexing: define RIP_BP_GSHARE_EN (default build is bimodal).
// Ports:
//   clk, rstn            clock / async active-low reset
//   i_lookup_valid/pc    fetch lookup request
//   o_pred_*             registered prediction (valid, taken, index, history)
//   i_update_*           resolved branch training / GHR recovery
//   o_ready              table sweep finished
module rip_branch_pht #(
  parameter  int BP_PC_LSB   = 2,
  parameter  int BP_PC_MSB   = 11,
  localparam int TABLE_DEPTH = BP_PC_MSB - BP_PC_LSB + 1,
  localparam int HISTORY_LEN = TABLE_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_lookup_valid,
  input  logic [31:0]            i_lookup_pc,
  output logic                   o_pred_valid,
  output logic                   o_pred_taken,
  output logic [TABLE_DEPTH-1:0] o_pred_index,
  output logic [HISTORY_LEN-1:0] o_pred_history,
  input  logic                   i_update_valid,
  input  logic [TABLE_DEPTH-1:0] i_update_index,
  input  logic                   i_update_taken,
  input  logic                   i_update_mispred,
  input  logic [HISTORY_LEN-1:0] i_update_history,
  output logic                   o_ready
);

  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'b00,
    WEAKLY_UNTAKEN   = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONGLY_TAKEN   = 2'b11
  } bp_weight_t;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [TABLE_DEPTH-1:0] r_sweep, w_sweep_nxt;
  bp_weight_t             r_pht [2**TABLE_DEPTH];

  logic [HISTORY_LEN-1:0] w_ghr;
  logic [TABLE_DEPTH-1:0] w_lookup_idx;
  logic                   w_run, w_upd_en, w_lk_taken;
  bp_weight_t             w_upd_old, w_upd_new, w_lk_ctr;

  // Whole PC is folded here so the unused high/low bits do not trip lint.
  logic w_unused_pc;
  assign w_unused_pc = ^i_lookup_pc;

  assign w_run    = (r_state == S_RUN);
  assign w_upd_en = w_run && i_update_valid;

  // FSM: sweep every entry once after reset, then serve lookups.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    if (r_state == S_INIT) begin
      w_sweep_nxt = r_sweep + 1'b1;
      if (&r_sweep) w_state_nxt = S_RUN;
    end
  end

  assign o_ready = w_run;

`ifdef RIP_BP_GSHARE_EN
  logic [HISTORY_LEN-1:0] r_ghr;
  assign w_ghr = r_ghr;

  // Misprediction recovery has priority over the speculative lookup shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_ghr <= '0;
    else if (w_upd_en && i_update_mispred)
      r_ghr <= {i_update_history[HISTORY_LEN-2:0], i_update_taken};
    else if (w_run && i_lookup_valid)
      r_ghr <= {r_ghr[HISTORY_LEN-2:0], w_lk_taken};
  end
`else
  logic w_unused_hist;
  assign w_ghr         = '0;
  assign w_unused_hist = ^{i_update_history, i_update_mispred};
`endif

  assign w_lookup_idx = i_lookup_pc[BP_PC_MSB:BP_PC_LSB] ^ w_ghr;

  // Saturating read-modify-write for the single update port.
  always_comb begin
    w_upd_old = r_pht[i_update_index];
    w_upd_new = w_upd_old;
    if (i_update_taken) begin
      if (w_upd_old != STRONGLY_TAKEN) w_upd_new = bp_weight_t'(w_upd_old + 2'd1);
    end else begin
      if (w_upd_old != STRONGLY_UNTAKEN) w_upd_new = bp_weight_t'(w_upd_old - 2'd1);
    end
  end

  // Same-cycle update to the looked-up entry is forwarded into the prediction.
  assign w_lk_ctr   = (w_upd_en && (i_update_index == w_lookup_idx)) ? w_upd_new
                                                                     : r_pht[w_lookup_idx];
  assign w_lk_taken = w_run && w_lk_ctr[1];

  // Table storage is not reset; the INIT sweep initialises it.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT)
      r_pht[r_sweep] <= WEAKLY_UNTAKEN;
    else if (w_upd_en)
      r_pht[i_update_index] <= w_upd_new;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_pred_valid   <= 1'b0;
      o_pred_taken   <= 1'b0;
      o_pred_index   <= '0;
      o_pred_history <= '0;
    end else begin
      o_pred_valid <= i_lookup_valid;
      if (i_lookup_valid) begin
        o_pred_taken   <= w_lk_taken;
        o_pred_index   <= w_lookup_idx;
        o_pred_history <= w_ghr;
      end
    end
  end

endmodule

// File: tb/tb_rip_branch_pht.sv
module tb_rip_branch_pht;
  localparam int TD = 10;
  localparam int N  = 1 << TD;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_lookup_valid;
  logic [31:0]   i_lookup_pc;
  logic          o_pred_valid, o_pred_taken;
  logic [TD-1:0] o_pred_index, o_pred_history;
  logic          i_update_valid, i_update_taken, i_update_mispred;
  logic [TD-1:0] i_update_index, i_update_history;
  logic          o_ready;

  rip_branch_pht dut (
    .clk(clk), .rstn(rstn),
    .i_lookup_valid(i_lookup_valid), .i_lookup_pc(i_lookup_pc),
    .o_pred_valid(o_pred_valid), .o_pred_taken(o_pred_taken),
    .o_pred_index(o_pred_index), .o_pred_history(o_pred_history),
    .i_update_valid(i_update_valid), .i_update_index(i_update_index),
    .i_update_taken(i_update_taken), .i_update_mispred(i_update_mispred),
    .i_update_history(i_update_history), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: counter values as plain integers 0..3, GHR as an integer.
  int          ctr [N];
  int          ghr;
  logic        e_taken;
  logic [TD-1:0] e_idx, e_hist;

  function automatic bit gshare();
`ifdef RIP_BP_GSHARE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) ctr[i] = 1;
    ghr = 0; e_taken = 0; e_idx = '0; e_hist = '0;
  endtask

  // One RUN-mode cycle: drive, predict with the model, clock, check.
  task automatic step(input bit lv, input logic [31:0] pc, input bit uv,
                      input logic [TD-1:0] ui, input bit ut, input bit um,
                      input logic [TD-1:0] uh);
    int nu, lc, li;
    i_lookup_valid = lv; i_lookup_pc = pc;
    i_update_valid = uv; i_update_index = ui; i_update_taken = ut;
    i_update_mispred = um; i_update_history = uh;
    nu = ut ? ((ctr[ui] == 3) ? 3 : ctr[ui] + 1) : ((ctr[ui] == 0) ? 0 : ctr[ui] - 1);
    li = (pc >> 2) % N;
    if (gshare()) li = li ^ ghr;
    lc = (uv && (ui == li)) ? nu : ctr[li];
    if (lv) begin
      e_taken = (lc >= 2); e_idx = li[TD-1:0]; e_hist = ghr[TD-1:0];
    end
    if (uv) ctr[ui] = nu;
    if (gshare()) begin
      if (uv && um)   ghr = ((uh * 2) + ut) % N;
      else if (lv)    ghr = ((ghr * 2) + e_taken) % N;
    end
    @(posedge clk); #1;
    chk("valid", o_pred_valid, lv);
    chk("taken", o_pred_taken, e_taken);
    chk("index", o_pred_index, e_idx);
    chk("history", o_pred_history, e_hist);
    chk("ready", o_ready, 1);
  endtask

  task automatic idle_inputs();
    i_lookup_valid = 0; i_lookup_pc = '0; i_update_valid = 0; i_update_index = '0;
    i_update_taken = 0; i_update_mispred = 0; i_update_history = '0;
  endtask

  // Counts edges after reset release; o_ready must rise exactly at edge N.
  task automatic run_init(input string tag);
    for (int n = 1; n <= N; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        chk({tag, "_init_valid"}, o_pred_valid, 1);
        chk({tag, "_init_taken"}, o_pred_taken, 0);
        chk({tag, "_init_index"}, o_pred_index, 10'h040);
        i_lookup_valid = 0;
      end
      if (n == N - 1) chk({tag, "_ready_low"}, o_ready, 0);
      if (n == N)     chk({tag, "_ready_high"}, o_ready, 1);
    end
    e_taken = 0; e_idx = 10'h040; e_hist = '0;
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    model_reset();
    #12;
    chk("rst_valid", o_pred_valid, 0);
    chk("rst_taken", o_pred_taken, 0);
    chk("rst_index", o_pred_index, 0);
    chk("rst_history", o_pred_history, 0);
    chk("rst_ready", o_ready, 0);
    @(posedge clk); #1;
    rstn = 1;
    i_lookup_valid = 1; i_lookup_pc = 32'h100;
    run_init("a");

    step(1, 32'h100, 0, '0, 0, 0, '0);
    chk("post_init_taken", o_pred_taken, 0);

`ifndef RIP_BP_GSHARE_EN
    for (int k = 0; k < 3; k++) step(0, '0, 1, 10'h040, 1, 0, '0);
    step(1, 32'h100, 0, '0, 0, 0, '0);
    chk("bim_sat_taken", o_pred_taken, 1);
    step(0, '0, 1, 10'h040, 0, 0, '0);
    step(1, 32'h100, 0, '0, 0, 0, '0);
    chk("bim_dec_taken", o_pred_taken, 1);
    // Bypass: entry 0x080 is still weakly-untaken; update+lookup together.
    step(1, 32'h200, 1, 10'h080, 1, 0, '0);
    chk("bypass_taken", o_pred_taken, 1);
`endif

    for (int c = 0; c < 3000; c++) begin
      logic [TD-1:0] ui;
      logic [31:0]   pc;
      ui = $urandom_range(0, 15);
      pc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1)) pc = {20'h0, 6'h0, ui ^ $urandom_range(0, 3), 2'b00} & 32'h0000_0FFC;
      step($urandom_range(0, 1), pc, $urandom_range(0, 1), ui,
           $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom);
    end

    // Reset mid-sweep: outputs must drop without waiting for a clock edge.
    idle_inputs();
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    for (int n = 0; n < 500; n++) begin
      i_lookup_valid = (n == 499);
      i_lookup_pc = 32'h100;
      @(posedge clk); #1;
    end
    chk("mid_valid_pre", o_pred_valid, 1);
    #2 rstn = 0;
    #1;
    chk("mid_rst_valid", o_pred_valid, 0);
    chk("mid_rst_index", o_pred_index, 0);
    chk("mid_rst_ready", o_ready, 0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    i_lookup_valid = 1; i_lookup_pc = 32'h100;
    run_init("b");
    for (int c = 0; c < 200; c++)
      step($urandom_range(0, 1), {$urandom_range(0, 1023), 2'b00}, $urandom_range(0, 1),
           $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 1), $urandom);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rip_branch_pht.md
# rip_branch_pht

Pattern history table for the fetch-stage branch predictor: an array of 2-bit saturating counters (`bp_weight_t` encoding, bimodal/gshare flavour) indexed from the fetch PC. It returns a registered taken/not-taken prediction one cycle after a lookup and trains counters from resolved branches in execute. It sits between the fetch PC generator upstream and the next-PC mux / execute-stage branch resolution downstream.

## Interface
- `BP_PC_LSB`, default 2: lowest PC bit used for the index.
- `BP_PC_MSB`, default 11: highest PC bit used for the index.
- `TABLE_DEPTH = BP_PC_MSB-BP_PC_LSB+1` (derived, 10): index width; the table has 2^TABLE_DEPTH entries.
- `HISTORY_LEN = TABLE_DEPTH` (derived): global history width.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `i_lookup_valid` in 1: lookup request this cycle.
- `i_lookup_pc` in 32: fetch PC.
- `o_pred_valid` out 1: prediction valid (registered).
- `o_pred_taken` out 1: counter MSB of the looked-up entry.
- `o_pred_index` out TABLE_DEPTH: index used; carried down the pipeline for update.
- `o_pred_history` out HISTORY_LEN: GHR value before this lookup's speculative shift; carried for recovery.
- `i_update_valid` in 1: resolved conditional branch.
- `i_update_index` in TABLE_DEPTH: index returned at prediction time.
- `i_update_taken` in 1: actual outcome.
- `i_update_mispred` in 1: prediction was wrong.
- `i_update_history` in HISTORY_LEN: `o_pred_history` returned at prediction time.
- `o_ready` out 1: table initialised.

## Operation
- FSM states: INIT, RUN. Reset enters INIT with sweep counter 0.
- INIT: one entry per cycle written to WEAKLY_UNTAKEN (01), index = sweep counter; after entry 2^TABLE_DEPTH-1 goes to RUN next cycle. Lookups give `o_pred_valid`=1, `o_pred_taken`=0; updates are dropped.
- RUN: `o_ready`=1.
- Index = `i_lookup_pc[BP_PC_MSB:BP_PC_LSB]` (XOR GHR when `GSHARE_EN` is defined).
- Update: 2-bit saturating counter: taken increments, saturating at 11. Not-taken decrements, saturating at 00. Read-modify-write completes in the update cycle.
- Same-cycle lookup and update to the same index: the prediction uses the post-update counter (bypass).
- Counters are single-ported for writes. Only the one update entry changes per cycle.
- Reset mid-operation: FSM returns to INIT and the sweep restarts at 0. Outputs take their reset values immediately.

## Timing
- Lookup latency 1 cycle: request at edge N, `o_pred_*` valid after edge N+1. No stall input, and a new lookup is accepted every cycle.
- `o_pred_valid` mirrors the previous cycle's `i_lookup_valid`. Other `o_pred_*` hold their last value when no lookup is issued.
- Update visible to lookups in the same cycle (bypass) and in all later cycles.
- Reset values: `o_pred_valid`=0, `o_pred_taken`=0, `o_pred_index`=0, `o_pred_history`=0, `o_ready`=0, GHR=0, FSM=INIT.
- INIT lasts exactly 2^TABLE_DEPTH cycles after reset deassertion; `o_ready` rises on the following edge.

## Configuration
- `RIP_BP_GSHARE_EN` defined:
  - Global history register (HISTORY_LEN bits) is instantiated and index = PC bits XOR GHR.
  - On a RUN lookup, GHR shifts left with the predicted direction inserted at bit 0.
  - On `i_update_valid && i_update_mispred`, GHR <= {`i_update_history`[HISTORY_LEN-2:0], `i_update_taken`}. Recovery wins over a same-cycle lookup shift, and that lookup's prediction uses the pre-recovery GHR.
- Undefined (bimodal):
  - No GHR; index = PC bits only.
  - `o_pred_history` is tied to 0 and `i_update_history`/`i_update_mispred` are ignored.

## Test plan
- Reset then idle 1024 cycles -> `o_ready` stays 0 through cycle 1023 and rises at cycle 1024. Lookup of PC 0x100 then returns taken=0.
- Bimodal, three taken updates to index 0x040 (PC 0x100) -> counter 01->10->11->11. Lookup returns taken=1. One not-taken update gives 10, and a lookup still returns taken=1.
- Same-cycle update (taken, index 0x040, counter 01) and lookup of PC 0x100 -> `o_pred_taken`=1 next cycle (bypass).
- GSHARE: GHR=0x001, lookup PC 0x104 -> `o_pred_index`=0x040, `o_pred_history`=0x001. The GHR shifts to 0x002 when the prediction is not-taken.
- GSHARE: mispredict update with history 0x155 and taken=1, concurrent with a lookup -> GHR=0x2AB next cycle (recovery wins).
- Assert `rstn` low mid-sweep at entry 500 -> outputs zero immediately. After release, `o_ready` rises 1024 cycles later.
